// File: rtl/switch_debounce_if.sv
// switch_debounce_if: pad-side and read-port-side signals of the switch debouncer.
//   master : drives raw pads and the acknowledge (board model / read path)
//   slave  : the debouncer; drives the clean switch word, button level,
//            confirm pulse and sticky confirmation flag
// Signals:
//   sw_raw[N_SW]   asynchronous switch pads
//   btn_raw        asynchronous confirm button pad (high = pressed)
//   confirm_ack    one-cycle clear of the confirmation flag
//   sw_stable      debounced switch word
//   btn_level      debounced button level
//   confirm_pulse  one-cycle pulse on debounced button rising edge
//   confirmation   sticky "pressed since last ack" flag
interface switch_debounce_if #(
    parameter int N_SW = 16
);
    logic [N_SW-1:0] sw_raw;
    logic            btn_raw;
    logic            confirm_ack;
    logic [N_SW-1:0] sw_stable;
    logic            btn_level;
    logic            confirm_pulse;
    logic            confirmation;

    modport master (
        output sw_raw, btn_raw, confirm_ack,
        input  sw_stable, btn_level, confirm_pulse, confirmation
    );

    modport slave (
        input  sw_raw, btn_raw, confirm_ack,
        output sw_stable, btn_level, confirm_pulse, confirmation
    );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: conditions the DIP switches and the confirm button for the
// memory-mapped switch read port.
//   raw pads -> SYNC_STAGES-flop synchroniser -> per-bit sample filter on a
//   slow tick -> sw_stable / btn_level; btn_level rising edge -> confirm_pulse
//   -> sticky confirmation flag cleared by confirm_ack.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low; clears every flop
//   bus  switch_debounce_if.slave (pads, ack, conditioned outputs)
// Build option:
//   SWITCH_DEBOUNCE_BYPASS_EN - drops the tick counter and filter; outputs are
//   the synchroniser outputs registered once (for fast CPU-level simulation).
module switch_debounce #(
    parameter int N_SW           = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TICK_CYCLES    = 100000,
    parameter int STABLE_SAMPLES = 4
) (
    input logic           clk,
    input logic           rst,
    switch_debounce_if.slave bus
);
    // Button rides along as the top lane so it shares the switch datapath.
    localparam int W = N_SW + 1;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  sync_out;
    logic [W-1:0]                  filt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {bus.btn_raw, bus.sw_raw};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef SWITCH_DEBOUNCE_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!rst) filt <= '0;
        else      filt <= sync_out;
    end
`else
    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));

    // Free-running sample timebase, not restarted by input activity.
    always_ff @(posedge clk) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    for (genvar b = 0; b < W; b++) begin : g_lane
        logic [STABLE_SAMPLES-1:0] hist;
        logic [STABLE_SAMPLES-1:0] hist_next;
        logic                      out_q;

        assign hist_next = {hist[STABLE_SAMPLES-2:0], sync_out[b]};
        assign filt[b]   = out_q;

        // Decide on the post-shift history so a full run of equal samples
        // updates the output on the same edge as the last sample.
        always_ff @(posedge clk) begin
            if (!rst) begin
                hist  <= '0;
                out_q <= 1'b0;
            end else if (tick) begin
                hist <= hist_next;
                if (&hist_next)       out_q <= 1'b1;
                else if (~|hist_next) out_q <= 1'b0;
            end
        end
    end
`endif

    logic btn_level_d;
    logic pulse;
    logic conf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_level_d <= 1'b0;
            pulse       <= 1'b0;
            conf        <= 1'b0;
        end else begin
            btn_level_d <= filt[N_SW];
            pulse       <= filt[N_SW] & ~btn_level_d;
            // Set has priority so a press coinciding with an ack is kept.
            if (pulse)                conf <= 1'b1;
            else if (bus.confirm_ack) conf <= 1'b0;
        end
    end

    assign bus.sw_stable     = filt[N_SW-1:0];
    assign bus.btn_level     = filt[N_SW];
    assign bus.confirm_pulse = pulse;
    assign bus.confirmation  = conf;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: self-checking bench for switch_debounce (default build).
// A behavioural model tracks sampled raw values, ticks by cycle arithmetic and
// decides outputs from the last STAB tick samples; it is compared every cycle.
// Directed sequences and a vector table cover latency, glitch, ack and reset.
module tb_switch_debounce;
    localparam int N_SW = 16;
    localparam int SYNC = 2;
    localparam int TICK = 4;
    localparam int STAB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    switch_debounce_if #(.N_SW(N_SW)) bus ();

    switch_debounce #(
        .N_SW(N_SW), .SYNC_STAGES(SYNC), .TICK_CYCLES(TICK), .STABLE_SAMPLES(STAB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N_SW:0] raw_q[$];
    logic [N_SW:0] smp_q[$];
    longint        m_k;
    logic [N_SW:0] m_out;
    logic          m_lvl_d, m_pulse, m_conf;
    bit            m_valid = 0;

    always @(posedge clk) begin
        logic [N_SW:0] synced, all1, any1;
        logic          nxt_pulse, nxt_conf;
        if (!rst) begin
            raw_q.delete();
            smp_q.delete();
            for (int i = 0; i < STAB; i++) smp_q.push_back('0);
            m_k = 0; m_out = '0; m_lvl_d = 1'b0; m_pulse = 1'b0; m_conf = 1'b0;
        end else begin
            // value seen by the filter = raw sampled SYNC edges earlier
            synced = (raw_q.size() >= SYNC) ? raw_q[raw_q.size()-SYNC] : '0;
            raw_q.push_back({bus.btn_raw, bus.sw_raw});
            if (raw_q.size() > SYNC) void'(raw_q.pop_front());
            nxt_pulse = m_out[N_SW] & ~m_lvl_d;
            nxt_conf  = m_pulse ? 1'b1 : (bus.confirm_ack ? 1'b0 : m_conf);
            m_lvl_d   = m_out[N_SW];
            if (m_k % TICK == TICK - 1) begin
                smp_q.push_back(synced);
                void'(smp_q.pop_front());
                all1 = '1; any1 = '0;
                foreach (smp_q[i]) begin
                    all1 &= smp_q[i];
                    any1 |= smp_q[i];
                end
                m_out = all1 | (m_out & any1);
            end
            m_pulse = nxt_pulse;
            m_conf  = nxt_conf;
            m_k++;
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid)
            check("model", 32'({bus.sw_stable, bus.btn_level, bus.confirm_pulse, bus.confirmation}),
                  32'({m_out[N_SW-1:0], m_out[N_SW], m_pulse, m_conf}));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [N_SW-1:0] sw;
        logic            btn;
        logic            ack;
        int              hold;
        logic [N_SW-1:0] exp_sw;
        logic            exp_lvl;
        logic            exp_conf;
    } vec_t;

    vec_t vecs[8];

    task automatic ack_once();
        @(negedge clk); bus.confirm_ack = 1'b1;
        @(negedge clk); bus.confirm_ack = 1'b0;
    endtask

    initial begin
        int n, pulses, pulses_rel;
        bit ok, found;

        vecs[0] = '{16'h0000, 1'b0, 1'b1, 20, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 1'b0, 1'b0, 20, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{16'hA5A5, 1'b1, 1'b0, 20, 16'hA5A5, 1'b1, 1'b1};
        vecs[3] = '{16'h5A5A, 1'b1, 1'b1, 20, 16'h5A5A, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 1'b0, 1'b0, 20, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'h8001, 1'b1, 1'b0, 20, 16'h8001, 1'b1, 1'b1};
        vecs[6] = '{16'h8001, 1'b0, 1'b0, 20, 16'h8001, 1'b0, 1'b1};
        vecs[7] = '{16'h8001, 1'b1, 1'b1, 20, 16'h8001, 1'b1, 1'b0};

        // 1. reset with all inputs high, then release latency
        bus.sw_raw = '1; bus.btn_raw = 1'b1; bus.confirm_ack = 1'b0; rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_outs", 32'({bus.sw_stable, bus.btn_level, bus.confirm_pulse, bus.confirmation}), 32'h0);
        end
        @(negedge clk); rst = 1'b1;
        n = 0; found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.sw_stable == 16'hFFFF) begin found = 1; n = c; end
        end
        check_range("reset_latency", found ? n : 99, 11, 14);

        // 2. glitch shorter than TICK*(STAB-1)
        @(negedge clk); bus.sw_raw = '0; bus.btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        ack_once();
        ok = 1;
        bus.sw_raw = 16'h00A5;
        repeat (6) begin @(negedge clk); if (bus.sw_stable != 16'h0) ok = 0; end
        bus.sw_raw = 16'h0000;
        repeat (20) begin @(negedge clk); if (bus.sw_stable != 16'h0) ok = 0; end
        check("glitch", 32'(ok), 32'd1);

        // 3. steady change, unchanged bits never toggle
        bus.sw_raw = 16'h1234;
        ok = 1; found = 0; n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((bus.sw_stable & ~16'h1234) != 16'h0) ok = 0;
            if (!found && bus.sw_stable == 16'h1234) begin found = 1; n = c; end
            if (found && bus.sw_stable != 16'h1234) ok = 0;
        end
        check("steady_other_bits", 32'(ok), 32'd1);
        check_range("steady_latency", found ? n : 99, 11, 14);

        // 4. button press: one pulse, sticky flag, no pulse on release
        check("conf_before_press", 32'(bus.confirmation), 32'd0);
        bus.btn_raw = 1'b1; pulses = 0; pulses_rel = 0;
        repeat (20) begin @(negedge clk); if (bus.confirm_pulse) pulses++; end
        check("press_pulses", 32'(pulses), 32'd1);
        check("press_conf", 32'(bus.confirmation), 32'd1);
        bus.btn_raw = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.confirm_pulse) pulses_rel++; end
        check("release_pulses", 32'(pulses_rel), 32'd0);
        check("release_conf", 32'(bus.confirmation), 32'd1);

        // 5. ack clears; ack coinciding with pulse loses to set
        ack_once();
        check("ack_clear", 32'(bus.confirmation), 32'd0);
        bus.btn_raw = 1'b1; found = 0;
        for (int c = 0; c < 25 && !found; c++) begin
            @(negedge clk);
            if (bus.confirm_pulse) found = 1;
        end
        check("collide_pulse_seen", 32'(found), 32'd1);
        bus.confirm_ack = 1'b1;
        @(negedge clk); bus.confirm_ack = 1'b0;
        check("collide_conf", 32'(bus.confirmation), 32'd1);

        // 6. reset mid-filter discards partial history
        bus.btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        bus.btn_raw = 1'b1;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        check("midrst_level", 32'(bus.btn_level), 32'd0);
        ok = 1; found = 0; n = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.btn_level) begin found = 1; n = c; end
            else if (bus.confirm_pulse) ok = 0;
        end
        check("midrst_no_early_pulse", 32'(ok), 32'd1);
        check_range("midrst_latency", found ? n : 99, 11, 14);

        // vector table
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.sw_raw = vecs[i].sw; bus.btn_raw = vecs[i].btn; bus.confirm_ack = vecs[i].ack;
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("vec%0d_sw", i), 32'(bus.sw_stable), 32'(vecs[i].exp_sw));
            check($sformatf("vec%0d_lvl", i), 32'(bus.btn_level), 32'(vecs[i].exp_lvl));
            check($sformatf("vec%0d_conf", i), 32'(bus.confirmation), 32'(vecs[i].exp_conf));
        end
        bus.confirm_ack = 1'b0;

        // randomized segments, checked by the model every cycle
        for (int s = 0; s < 60; s++) begin
            int hold;
            hold = int'($urandom_range(1, 20));
            @(negedge clk);
            bus.sw_raw  = (($urandom_range(0, 1) == 0) ? bus.sw_raw : 16'($urandom));
            bus.btn_raw = 1'($urandom_range(0, 1));
            for (int h = 0; h < hold; h++) begin
                bus.confirm_ack = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
                @(negedge clk);
            end
            rst = 1'b1;
            bus.confirm_ack = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
Front-end conditioning stage for the board's 16 DIP switches and the confirm push-button. It sits directly upstream of the memory-mapped switch read port and feeds it a clean switch word plus a sticky confirmation flag.
- Raw pad inputs are synchronised, then sample-filtered on a slow tick.
- The confirm button's debounced rising edge is turned into a flag that the CPU-side read path clears with an acknowledge.

Parameters:
N_SW, 16, number of switch bits.
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (minimum 2).
TICK_CYCLES, 100000, clk cycles between filter samples (minimum 1).
STABLE_SAMPLES, 4, consecutive equal samples required to change a debounced output (minimum 2).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-low.
sw_raw  input  N_SW  asynchronous switch pads.
btn_raw  input  1  asynchronous confirm button pad, high = pressed.
confirm_ack  input  1  one-cycle clear of the confirmation flag; the read path drives it when the confirm address is read.
sw_stable  output  N_SW  debounced switch word.
btn_level  output  1  debounced button level.
confirm_pulse  output  1  one-cycle pulse on the debounced button rising edge.
confirmation  output  1  sticky "button pressed since last ack" flag.

Behaviour:
- Reset: rst sampled low on a clk edge clears everything. This covers synchroniser flops, tick counter, sample histories, sw_stable, btn_level, confirm_pulse and confirmation, all to 0. Reset mid-filter discards partial histories.
- Synchroniser: each of the N_SW+1 inputs passes through a chain of SYNC_STAGES flops. There is no filtering inside the chain.
- Tick counter:
  - counts 0..TICK_CYCLES-1 and wraps to 0;
  - tick is asserted (internal, one cycle) while count == TICK_CYCLES-1;
  - free-running, independent of input activity.
- Filter, per bit:
  - history is an STABLE_SAMPLES-bit shift register, shifted on tick only, taking the synchroniser output.
  - If the post-shift history is all ones, the output is set to 1 on that same edge.
  - If it is all zeros, the output is cleared to 0.
  - Otherwise the output holds.
  - Bits are independent.
- Latency: a raw change held steady reaches the output between SYNC_STAGES + TICK_CYCLES*(STABLE_SAMPLES-1) + 1 and SYNC_STAGES + TICK_CYCLES*STABLE_SAMPLES cycles.
- Glitch rejection: a pulse shorter than TICK_CYCLES*(STABLE_SAMPLES-1) cycles never changes the output.
- Edge detect:
  - btn_level_d is btn_level registered;
  - confirm_pulse = 1 for exactly one cycle, the cycle after btn_level goes 0->1;
  - a falling edge produces no pulse.
- Confirmation flag:
  - set on confirm_pulse, cleared on confirm_ack;
  - if both occur in the same cycle, set wins, so a press is never lost;
  - ack while the flag is already 0 has no effect;
  - repeated presses before an ack leave the flag at 1, with no count kept.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro SWITCH_DEBOUNCE_BYPASS_EN, intended for fast CPU-level simulation.
- Defined:
  - the filter and tick counter are removed;
  - sw_stable and btn_level are the synchroniser outputs registered once, so latency is SYNC_STAGES+1 cycles;
  - edge detect and the confirmation flag are unchanged.
- Not defined: full filtering as described above.

Test Plan:
(Parameters for all cases: N_SW=16, SYNC_STAGES=2, TICK_CYCLES=4, STABLE_SAMPLES=3.)
1. Reset: rst=0 for 3 cycles with sw_raw=16'hFFFF and btn_raw=1 -> all outputs 0 during reset; after release, sw_stable reaches 16'hFFFF within 14 cycles and not before cycle 11.
2. Glitch: sw_raw 16'h0000 -> 16'h00A5 for 6 cycles -> 16'h0000 -> sw_stable stays 16'h0000 throughout.
3. Steady change: sw_raw=16'h1234 held -> sw_stable=16'h1234 within 14 cycles; bits that did not change never toggle.
4. Button press: btn_raw 0->1 held 20 cycles -> exactly one confirm_pulse; confirmation goes 1 and stays 1 after release.
5. Ack and collision:
   - confirm_ack one cycle -> confirmation 0 next cycle.
   - New press timed so confirm_pulse and confirm_ack coincide -> confirmation remains 1.
6. Mid-filter reset: btn_raw=1 for 9 cycles, then rst=0 for one cycle, btn_raw kept 1 -> btn_level stays 0 until a full 3-sample history re-accumulates after reset. No confirm_pulse is emitted before that.
